// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// One-word lines; stalls the pipeline through hit=0 while main memory is busy.
module dcache_ctrl #(
    parameter int LINES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        hit,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [15:0] miss_cnt
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RMISS = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             line_hit;
    logic             fill;
    logic             upd;
    logic             count_miss;

    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      data_mem [LINES];

    assign idx       = cpu_addr[IDX_W+1:2];
    assign tag       = cpu_addr[31:IDX_W+2];
    assign line_hit  = valid[idx] && (tag_mem[idx] == tag);

    // The indexed line is always presented, so rdata never depends on control state.
    assign cpu_rdata = data_mem[idx];
    assign mem_addr  = cpu_addr & ~32'h3;
    assign mem_wdata = cpu_wdata;

    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        state_nxt  = state;
        hit        = 1'b1;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        fill       = 1'b0;
        upd        = 1'b0;
        count_miss = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_write) begin
                    hit       = 1'b0;
                    state_nxt = WRITE;
                end else if (cpu_read && !line_hit) begin
                    hit        = 1'b0;
                    count_miss = 1'b1;
                    state_nxt  = RMISS;
                end
            end
            RMISS: begin
                hit     = 1'b0;
                mem_req = 1'b1;
                if (mem_ready) begin
                    fill      = 1'b1;
                    state_nxt = DONE;
                end
            end
            WRITE: begin
                hit     = 1'b0;
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_ready) begin
                    // No allocation: only a line already holding this address is refreshed.
                    upd       = line_hit;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            valid    <= '0;
            miss_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (fill)
                valid[idx] <= 1'b1;
            if (count_miss)
                miss_cnt <= miss_cnt + 16'd1;
        end
    end

    // NOTE: tag/data arrays are not reset; the valid bits alone gate their use.
    always_ff @(posedge clk) begin
        if (fill) begin
            tag_mem[idx]  <= tag;
            data_mem[idx] <= mem_rdata;
        end else if (upd) begin
            data_mem[idx] <= cpu_wdata;
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: directed vector table, reset-abort sequence and
// randomized accesses checked against a line-level reference model.
module tb_dcache_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_read = 1'b0;
    logic        cpu_write = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        hit;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [15:0] miss_cnt;

    int total = 0;
    int bad   = 0;

    dcache_ctrl #(.LINES(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_read  (cpu_read),
        .cpu_write (cpu_write),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .hit       (hit),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .miss_cnt  (miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference model: each line remembers which word address it holds.
    typedef struct {
        bit          v;
        logic [31:0] wa;
        logic [31:0] d;
    } mline_t;

    mline_t m_line [16];
    int     m_miss;

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) m_line[i].v = 1'b0;
        m_miss = 0;
    endfunction

    task automatic idle_inputs();
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        mem_ready = 1'b0;
        @(negedge clk);
        check("rst_hit", hit, 1);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_miss_cnt", miss_cnt, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    // One CPU access, called just after a posedge. Serves memory after n request cycles.
    task automatic access(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input int n, input logic [31:0] mrd,
                          output logic [31:0] rdata, output int stalls);
        cpu_read  = rd;
        cpu_write = wr;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        stalls    = 0;
        @(negedge clk);
        check("idle_mem_req", mem_req, 0);
        if (hit) begin
            rdata = cpu_rdata;
            @(posedge clk);
            #1 idle_inputs();
        end else begin
            stalls = 1;
            @(posedge clk);
            #1;
            for (int c = 1; c <= n; c++) begin
                @(negedge clk);
                if (!hit) stalls++;
                check("mem_req", mem_req, 1);
                check("mem_we", mem_we, wr);
                check("mem_addr", mem_addr, {addr[31:2], 2'b00});
                if (wr) check("mem_wdata", mem_wdata, wdata);
                if (c == n) begin
                    mem_ready = 1'b1;
                    mem_rdata = mrd;
                end
                @(posedge clk);
                #1 mem_ready = 1'b0;
                mem_rdata = $urandom;
            end
            @(negedge clk);
            check("done_hit", hit, 1);
            check("done_mem_req", mem_req, 0);
            rdata = cpu_rdata;
            @(posedge clk);
            #1 idle_inputs();
        end
    endtask

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          n;
        logic [31:0] mrd;
        int          exp_stalls;
        bit          chk_rd;
        logic [31:0] exp_rdata;
        int          exp_miss;
    } vec_t;

    vec_t vecs [12];

    initial begin
        logic [31:0] rdata;
        int          stalls;

        vecs[0]  = '{1'b1, 1'b0, 32'h40, 32'h0,        3, 32'hDEADBEEF, 4, 1'b1, 32'hDEADBEEF, 1};
        vecs[1]  = '{1'b1, 1'b0, 32'h40, 32'h0,        1, 32'h0,        0, 1'b1, 32'hDEADBEEF, 1};
        vecs[2]  = '{1'b0, 1'b1, 32'h40, 32'h12345678, 2, 32'h0,        3, 1'b1, 32'h12345678, 1};
        vecs[3]  = '{1'b1, 1'b0, 32'h40, 32'h0,        1, 32'h0,        0, 1'b1, 32'h12345678, 1};
        vecs[4]  = '{1'b0, 1'b1, 32'h80, 32'hAAAA5555, 1, 32'h0,        2, 1'b1, 32'h12345678, 1};
        vecs[5]  = '{1'b1, 1'b0, 32'h80, 32'h0,        1, 32'h0BADF00D, 2, 1'b1, 32'h0BADF00D, 2};
        vecs[6]  = '{1'b1, 1'b0, 32'h00, 32'h0,        2, 32'h11111111, 3, 1'b1, 32'h11111111, 3};
        vecs[7]  = '{1'b1, 1'b0, 32'h40, 32'h0,        1, 32'h22222222, 2, 1'b1, 32'h22222222, 4};
        vecs[8]  = '{1'b1, 1'b0, 32'h00, 32'h0,        1, 32'h33333333, 2, 1'b1, 32'h33333333, 5};
        vecs[9]  = '{1'b1, 1'b1, 32'h04, 32'h44444444, 1, 32'h0,        2, 1'b0, 32'h0,        5};
        vecs[10] = '{1'b1, 1'b0, 32'h04, 32'h0,        1, 32'h55555555, 2, 1'b1, 32'h55555555, 6};
        vecs[11] = '{1'b1, 1'b0, 32'h00, 32'h0,        1, 32'h0,        0, 1'b1, 32'h33333333, 6};

        do_reset();

        for (int i = 0; i < 12; i++) begin
            access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].n,
                   vecs[i].mrd, rdata, stalls);
            check($sformatf("vec%0d_stalls", i), stalls, vecs[i].exp_stalls);
            if (vecs[i].chk_rd) check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
            check($sformatf("vec%0d_miss_cnt", i), miss_cnt, vecs[i].exp_miss);
        end

        // Reset in the middle of a read miss, then a late mem_ready.
        cpu_read = 1'b1;
        cpu_addr = 32'h100;
        @(negedge clk);
        check("abort_idle_hit", hit, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("abort_rmiss_req", mem_req, 1);
        #2 rst = 1'b1;
        cpu_read = 1'b0;
        #1;
        check("abort_req_drop", mem_req, 0);
        check("abort_hit", hit, 1);
        check("abort_we", mem_we, 0);
        check("abort_miss_cnt", miss_cnt, 0);
        @(posedge clk);
        #1 mem_ready = 1'b1;
        mem_rdata = 32'hFEEDFACE;
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 mem_ready = 1'b0;
        @(negedge clk);
        check("abort_after_hit", hit, 1);
        check("abort_after_req", mem_req, 0);
        @(posedge clk);
        #1;
        access(1'b1, 1'b0, 32'h100, 32'h0, 1, 32'hCAFE0001, rdata, stalls);
        check("abort_reload_stalls", stalls, 2);
        check("abort_reload_rdata", rdata, 32'hCAFE0001);
        check("abort_reload_miss_cnt", miss_cnt, 1);

        // Randomized accesses against the model.
        do_reset();
        for (int t = 0; t < 300; t++) begin
            int          kind;
            bit          rd;
            bit          wr;
            int          n;
            logic [31:0] addr;
            logic [31:0] wdata;
            logic [31:0] mrd;
            int          li;
            int          exp_stalls;
            bit          chk;
            logic [31:0] exp_rd;

            kind  = $urandom_range(0, 9);
            addr  = 32'($urandom_range(0, 63)) << 2;
            wdata = $urandom;
            mrd   = $urandom;
            n     = $urandom_range(1, 4);
            li    = int'(addr[5:2]);
            rd    = (kind <= 5) || (kind == 9);
            wr    = (kind >= 6) && (kind <= 8) || (kind == 9);
            if (kind == 8) begin
                rd = 1'b0;
                wr = 1'b0;
            end

            if (!rd && !wr) begin
                cpu_addr = addr;
                @(negedge clk);
                check("rnd_idle_hit", hit, 1);
                check("rnd_idle_req", mem_req, 0);
                if (m_line[li].v) check("rnd_idle_rdata", cpu_rdata, m_line[li].d);
                @(posedge clk);
                #1;
                continue;
            end

            chk    = 1'b0;
            exp_rd = '0;
            if (wr) begin
                exp_stalls = 1 + n;
                if (m_line[li].v && m_line[li].wa == addr) m_line[li].d = wdata;
                chk    = m_line[li].v;
                exp_rd = m_line[li].d;
            end else if (m_line[li].v && m_line[li].wa == addr) begin
                exp_stalls = 0;
                chk        = 1'b1;
                exp_rd     = m_line[li].d;
            end else begin
                exp_stalls = 1 + n;
                m_miss++;
                m_line[li] = '{1'b1, addr, mrd};
                chk        = 1'b1;
                exp_rd     = mrd;
            end

            access(rd, wr, addr, wdata, n, mrd, rdata, stalls);
            check("rnd_stalls", stalls, exp_stalls);
            if (chk) check("rnd_rdata", rdata, exp_rd);
            check("rnd_miss_cnt", miss_cnt, m_miss[15:0]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
